// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//   Chooses which formation enemy fires next and which enemy-bullet slot the
//   shot goes into. Shots are attempted every FIRE_INTERVAL frames; the shooter
//   search starts at a round-robin pointer offset by a small LFSR jitter, and a
//   busy bit per slot caps the number of enemy bullets in flight.
// Ports
//   clk, Reset       clock, synchronous active-high reset
//   frame_tick       one-cycle pulse per video frame
//   enable           gameplay active
//   alive            per-enemy alive mask (enemy i may fire)
//   slot_free        per-slot pulse: that slot's bullet is gone
//   fire_ready       bullet mover accepts the launch
//   fire_valid       launch request, held until accepted or aborted
//   fire_enemy       shooter index, valid with fire_valid
//   fire_slot        slot index, valid with fire_valid
//   slots_busy       slot occupancy
module enemy_fire_scheduler #(
    parameter int          NUM_ENEMIES   = 9,
    parameter int          NUM_SLOTS     = 3,
    parameter int          FIRE_INTERVAL = 30,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic                   enable,
    input  logic [NUM_ENEMIES-1:0] alive,
    input  logic [NUM_SLOTS-1:0]   slot_free,
    input  logic                   fire_ready,
    output logic                   fire_valid,
    output logic [3:0]             fire_enemy,
    output logic [1:0]             fire_slot,
    output logic [NUM_SLOTS-1:0]   slots_busy
);

    localparam int             CW       = $clog2(FIRE_INTERVAL + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(FIRE_INTERVAL);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PICK, S_ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          frame_cnt_q, frame_cnt_d;
    logic [7:0]             lfsr_q, lfsr_d;
    logic [3:0]             rr_ptr_q, rr_ptr_d;
    logic                   fire_valid_q, fire_valid_d;
    logic [3:0]             fire_enemy_q, fire_enemy_d;
    logic [1:0]             fire_slot_q, fire_slot_d;
    logic [NUM_SLOTS-1:0]   slots_busy_q, slots_busy_d;

    logic [4:0]             start_sum;
    logic [3:0]             start_idx;
    logic                   enemy_found, slot_found;
    logic [3:0]             pick_enemy;
    logic [1:0]             pick_slot;

    // Shooter / slot search, evaluated combinationally every cycle but only
    // consumed in PICK.
    always_comb begin
        start_sum = {1'b0, rr_ptr_q} + {2'b00, lfsr_q[2:0]};
        start_idx = (start_sum >= 5'(NUM_ENEMIES)) ? 4'(start_sum - 5'(NUM_ENEMIES))
                                                   : 4'(start_sum);
        enemy_found = 1'b0;
        pick_enemy  = '0;
        // Descending scan so the smallest offset from start wins without a break.
        for (int k = NUM_ENEMIES - 1; k >= 0; k--) begin
            int idx;
            idx = int'(start_idx) + k;
            if (idx >= NUM_ENEMIES) idx = idx - NUM_ENEMIES;
            if (alive[4'(idx)]) begin
                enemy_found = 1'b1;
                pick_enemy  = 4'(idx);
            end
        end
        slot_found = 1'b0;
        pick_slot  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!slots_busy_q[2'(s)]) begin
                slot_found = 1'b1;
                pick_slot  = 2'(s);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        fire_valid_d = fire_valid_q;
        fire_enemy_d = fire_enemy_q;
        fire_slot_d  = fire_slot_q;
        lfsr_d       = lfsr_q;
        // Frees apply in every state; a launch below may set a different bit.
        slots_busy_d = slots_busy_q & ~slot_free;

        if (enable && frame_tick)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (!enable) begin
            state_d      = S_IDLE;
            fire_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_WAIT;
                    frame_cnt_d = CNT_LOAD;
                end
                S_WAIT: begin
                    if (frame_tick) begin
                        frame_cnt_d = frame_cnt_q - CNT_ONE;
                        if (frame_cnt_q == CNT_ONE) state_d = S_PICK;
                    end
                end
                S_PICK: begin
                    if (enemy_found && slot_found) begin
                        state_d      = S_ISSUE;
                        fire_enemy_d = pick_enemy;
                        fire_slot_d  = pick_slot;
                        fire_valid_d = 1'b1;
                    end else begin
                        // Nothing to do this frame; try again on the next tick.
                        state_d     = S_WAIT;
                        frame_cnt_d = CNT_ONE;
                    end
                end
                S_ISSUE: begin
                    if (fire_valid_q && fire_ready) begin
                        slots_busy_d[fire_slot_q] = 1'b1;
                        rr_ptr_d     = (fire_enemy_q == 4'(NUM_ENEMIES - 1)) ? 4'd0
                                                                             : fire_enemy_q + 4'd1;
                        fire_valid_d = 1'b0;
                        frame_cnt_d  = CNT_LOAD;
                        state_d      = S_WAIT;
                    end else if (!alive[fire_enemy_q]) begin
                        // Shooter died before launch: withdraw and re-pick.
                        fire_valid_d = 1'b0;
                        state_d      = S_PICK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= '0;
            lfsr_q       <= LFSR_SEED;
            rr_ptr_q     <= '0;
            fire_valid_q <= 1'b0;
            fire_enemy_q <= '0;
            fire_slot_q  <= '0;
            slots_busy_q <= '0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            lfsr_q       <= lfsr_d;
            rr_ptr_q     <= rr_ptr_d;
            fire_valid_q <= fire_valid_d;
            fire_enemy_q <= fire_enemy_d;
            fire_slot_q  <= fire_slot_d;
            slots_busy_q <= slots_busy_d;
        end
    end

    assign fire_valid = fire_valid_q;
    assign fire_enemy = fire_enemy_q;
    assign fire_slot  = fire_slot_q;
    assign slots_busy = slots_busy_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Bench for enemy_fire_scheduler: reference model predicts each launch
// (shooter, slot) into a scoreboard queue; a monitor pops and compares on
// every rising edge of fire_valid.
module tb_enemy_fire_scheduler;
    localparam int FI = 2;

    logic       clk = 1'b0;
    logic       Reset, frame_tick, enable, fire_ready;
    logic [8:0] alive;
    logic [2:0] slot_free;
    logic       fire_valid;
    logic [3:0] fire_enemy;
    logic [1:0] fire_slot;
    logic [2:0] slots_busy;

    always #5 clk = ~clk;

    enemy_fire_scheduler #(.FIRE_INTERVAL(FI)) dut (
        .clk(clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
        .alive(alive), .slot_free(slot_free), .fire_ready(fire_ready),
        .fire_valid(fire_valid), .fire_enemy(fire_enemy), .fire_slot(fire_slot),
        .slots_busy(slots_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct { int enemy; int slot; } exp_t;
    exp_t sb[$];

    logic [7:0] m_lfsr;
    int         m_rr;
    logic [2:0] m_busy;
    int         last_e, last_s;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Reference pick: start = (rr + jitter) mod 9, first alive from start, lowest free slot.
    function automatic bit model_pick(output int e, output int s);
        int start;
        bit fe, fs;
        start = (m_rr + int'(m_lfsr[2:0])) % 9;
        fe = 0; fs = 0; e = 0; s = 0;
        for (int k = 0; k < 9; k++)
            if (!fe && alive[(start + k) % 9]) begin fe = 1; e = (start + k) % 9; end
        for (int j = 0; j < 3; j++)
            if (!fs && !m_busy[j]) begin fs = 1; s = j; end
        return fe && fs;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_frame();
        frame_tick = 1'b1;
        if (enable && !Reset) m_lfsr = lfsr_step(m_lfsr);
        step();
        frame_tick = 1'b0;
    endtask

    // Runs nframes ticks (the last one moves WAIT->PICK), then the PICK edge.
    task automatic attempt(input int nframes, output bit fired);
        int e, s;
        repeat (nframes) do_frame();
        fired = model_pick(e, s);
        if (fired) begin
            sb.push_back('{enemy: e, slot: s});
            last_e = e; last_s = s;
        end
        chk("pick_latency_vld", fire_valid, 0);
        step();
        chk("issue_vld", fire_valid, fired);
    endtask

    task automatic accept();
        fire_ready = 1'b1;
        step();
        fire_ready = 1'b0;
        m_busy[last_s] = 1'b1;
        m_rr = (last_e + 1) % 9;
        chk("acc_vld", fire_valid, 0);
        chk("acc_busy", slots_busy, m_busy);
    endtask

    // Scoreboard monitor.
    initial begin
        bit   pv;
        exp_t x;
        pv = 0;
        forever begin
            @(posedge clk); #2;
            if (fire_valid === 1'b1 && !pv) begin
                if (sb.size() == 0) chk("sb_unexpected_launch", 1, 0);
                else begin
                    x = sb.pop_front();
                    chk("sb_enemy", fire_enemy, x.enemy);
                    chk("sb_slot", fire_slot, x.slot);
                end
            end
            pv = (fire_valid === 1'b1);
        end
    end

    initial begin
        bit f;
        int dropped;
        Reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; fire_ready = 1'b0;
        alive = 9'h1FF; slot_free = 3'b000;
        repeat (3) step();
        chk("rst_vld", fire_valid, 0);
        chk("rst_enemy", fire_enemy, 0);
        chk("rst_slot", fire_slot, 0);
        chk("rst_busy", slots_busy, 0);
        // Reset dominates active inputs.
        enable = 1'b1; fire_ready = 1'b1; frame_tick = 1'b1;
        repeat (4) step();
        chk("rst_wins_vld", fire_valid, 0);
        chk("rst_wins_busy", slots_busy, 0);
        frame_tick = 1'b0; fire_ready = 1'b0; enable = 1'b0;
        step();
        Reset = 1'b0; m_lfsr = 8'hA5; m_rr = 0; m_busy = '0;
        enable = 1'b1;
        step();                                   // IDLE -> WAIT

        // 1: first shot, jitter from LFSR after two shifts (0x95 -> 5).
        attempt(2, f);
        chk("t1_enemy", fire_enemy, 5);
        chk("t1_slot", fire_slot, 0);
        accept();
        chk("t1_busy", slots_busy, 3'b001);

        // 2: single survivor at 8, then single survivor at 0 (scan wraps).
        alive = 9'b100000000;
        attempt(2, f);
        chk("t2_enemy8", fire_enemy, 8);
        accept();
        alive = 9'b000000001;
        attempt(2, f);
        chk("t2_enemy0", fire_enemy, 0);
        chk("t2_slot2", fire_slot, 2);
        accept();
        chk("t3_busy_full", slots_busy, 3'b111);

        // 3: all slots busy -> attempts fail and retry each frame.
        alive = 9'h1FF;
        attempt(2, f);
        attempt(1, f);
        attempt(1, f);
        slot_free = 3'b010;
        step();
        slot_free = 3'b000;
        m_busy[1] = 1'b0;
        chk("t3_freed", slots_busy, 3'b101);
        attempt(1, f);
        chk("t3_slot1", fire_slot, 1);

        // 4: stall then shooter dies.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_vld", fire_valid, 1);
            chk("t4_hold_enemy", fire_enemy, last_e);
            chk("t4_hold_slot", fire_slot, last_s);
        end
        dropped = last_e;
        alive[dropped] = 1'b0;
        step();
        chk("t4_abort_vld", fire_valid, 0);
        begin
            int e, s;
            f = model_pick(e, s);
            if (f) begin sb.push_back('{enemy: e, slot: s}); last_e = e; last_s = s; end
        end
        step();
        chk("t4_repick_vld", fire_valid, f);
        chk("t4_excl", fire_enemy == 4'(dropped), 0);

        // 5: enable drop during ISSUE, LFSR frozen while disabled, reset in ISSUE.
        enable = 1'b0;
        step();
        chk("t5_dis_vld", fire_valid, 0);
        chk("t5_dis_busy", slots_busy, 3'b101);
        do_frame();
        do_frame();
        chk("t5_dis_idle", fire_valid, 0);
        enable = 1'b1; alive = 9'h1FF;
        step();
        attempt(2, f);
        chk("t5_slot", fire_slot, 1);
        Reset = 1'b1;
        step();
        chk("t5_rst_vld", fire_valid, 0);
        chk("t5_rst_enemy", fire_enemy, 0);
        chk("t5_rst_slot", fire_slot, 0);
        chk("t5_rst_busy", slots_busy, 0);
        Reset = 1'b0; m_lfsr = 8'hA5; m_rr = 0; m_busy = '0;
        step();                                   // IDLE -> WAIT

        // 6: nobody alive for 4 frames, LFSR keeps stepping.
        alive = 9'h000;
        attempt(2, f);
        attempt(1, f);
        attempt(1, f);
        chk("t6_busy", slots_busy, 0);
        alive = 9'h1FF;
        attempt(1, f);
        // Accept while freeing an already-free slot: free is a no-op.
        slot_free = 3'b100;
        accept();
        slot_free = 3'b000;
        step();
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
